// File: rtl/array_pkg.sv
// Shared constants and state encoding for the array_35 front-end controller.
// Purely declarative: no logic, no latency, no flow control.
package array_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 48;
    localparam int MASK_W = 8;
    localparam int LANE_W = DATA_W / MASK_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/array_35_ctrl_if.sv
// Client request/response channel plus the macro RW port of array_35_ctrl.
// slave = controller side, master = client/macro side.
interface array_35_ctrl_if #(
    parameter int ADDR_W = array_pkg::ADDR_W,
    parameter int DATA_W = array_pkg::DATA_W,
    parameter int MASK_W = array_pkg::MASK_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_mask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;
    logic              mem_en;
    logic              mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_mask, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, init_done,
               mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_mask, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, init_done,
               mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata
    );

endinterface

// File: rtl/array_resp_fifo.sv
// Small response FIFO with registered count; head is valid whenever count != 0.
// Push and pop in one cycle are both honoured; a push into a full FIFO without pop is dropped.
module array_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = slots[rd_ptr];

    // Payload storage needs no reset: count gates every read of it.
    always_ff @(posedge clock) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/array_35_ctrl.sv
// Zero-fills the 256x48 array after reset, then maps valid/ready requests onto its RW port.
// Read latency 2 cycles; reads stall once queued plus in-flight responses reach RESP_DEPTH, writes never stall.
module array_35_ctrl #(
    parameter int ADDR_W     = array_pkg::ADDR_W,
    parameter int DATA_W     = array_pkg::DATA_W,
    parameter int MASK_W     = array_pkg::MASK_W,
    parameter int RESP_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    array_35_ctrl_if.slave   bus
);

    import array_pkg::*;

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [ADDR_W-1:0] init_addr;
    logic              init_done_q;
    logic              inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W:0]    occ_next;
    logic              pop;
    logic              read_ok;
    logic              fire;

    assign pop      = bus.resp_valid && bus.resp_ready;
    // Occupancy after this cycle's pop; a new read must still find a free slot when it lands.
    assign occ_next = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign read_ok  = occ_next < (CNT_W + 1)'(RESP_DEPTH);

    assign bus.req_ready  = (state == RUN) && (bus.req_write || read_ok);
    assign fire           = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (fifo_count != '0);
    assign bus.resp_rdata = fifo_head;
    assign bus.init_done  = init_done_q;

    // Gating the init write with reset_n keeps the macro idle while reset is held.
    always_comb begin
        if (state == INIT) begin
            bus.mem_en    = reset_n;
            bus.mem_wmode = 1'b1;
            bus.mem_addr  = init_addr;
            bus.mem_wmask = {MASK_W{1'b1}};
            bus.mem_wdata = '0;
        end else begin
            bus.mem_en    = fire;
            bus.mem_wmode = bus.req_write;
            bus.mem_addr  = bus.req_addr;
            bus.mem_wmask = bus.req_mask;
            bus.mem_wdata = bus.req_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            init_addr   <= '0;
            init_done_q <= 1'b0;
            inflight    <= 1'b0;
        end else begin
            inflight <= (state == RUN) && fire && !bus.req_write;
            case (state)
                INIT: begin
                    if (init_addr == LAST_ADDR) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    array_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (bus.mem_rdata),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_array_35_ctrl.sv
// Bench for array_35_ctrl: behavioural macro, directed vector table, hand sequences and a randomized run
// checked against a queue-based reference of the array contents and response stream.
module tb_array_35_ctrl;

    import array_pkg::*;

    localparam int DEPTH = 2;
    localparam int NENT  = 1 << ADDR_W;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    array_35_ctrl_if ifc ();

    array_35_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MASK_W     (MASK_W),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < MASK_W; i++) begin
            if (m[i]) r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    // Macro model: one-cycle read latency, garbage on rdata whenever no read was issued.
    logic [DATA_W-1:0] macro_mem [NENT];
    always @(posedge clock) begin
        if (ifc.mem_en && ifc.mem_wmode)
            macro_mem[ifc.mem_addr] <= merge(macro_mem[ifc.mem_addr], ifc.mem_wdata, ifc.mem_wmask);
        if (ifc.mem_en && !ifc.mem_wmode)
            ifc.mem_rdata <= macro_mem[ifc.mem_addr];
        else
            ifc.mem_rdata <= DATA_W'({$urandom(), $urandom()});
    end

    // Reference: array contents and expected response stream with due cycles.
    logic [DATA_W-1:0] ref_mem [NENT];
    logic [DATA_W-1:0] exp_q [$];
    int                exp_t [$];
    logic [DATA_W-1:0] got_q [$];
    int  cycle;
    int  n_chk;
    int  n_pass;
    bit  last_acc;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic set_req(input bit v, input bit w, input logic [ADDR_W-1:0] a,
                           input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
        ifc.req_valid = v;
        ifc.req_write = w;
        ifc.req_addr  = a;
        ifc.req_mask  = m;
        ifc.req_wdata = d;
    endtask

    // One RUN-mode cycle: check outputs at the falling edge, update the reference, advance.
    task automatic tick();
        bit exp_vld;
        bit exp_rdy;
        bit acc;
        @(negedge clock);
        exp_vld = (exp_q.size() > 0) && (exp_t[0] <= cycle);
        chk("resp_valid", ifc.resp_valid, exp_vld);
        if (exp_vld) chk("resp_rdata", ifc.resp_rdata, exp_q[0]);
        exp_rdy = ifc.req_write || ((exp_q.size() - int'(exp_vld && ifc.resp_ready)) < DEPTH);
        if (ifc.req_valid) chk("req_ready", ifc.req_ready, exp_rdy);
        acc = ifc.req_valid && ifc.req_ready;
        chk("mem_en", ifc.mem_en, acc);
        if (acc) begin
            chk("mem_cmd", {ifc.mem_wmode, ifc.mem_addr}, {ifc.req_write, ifc.req_addr});
            if (ifc.req_write) begin
                ref_mem[ifc.req_addr] = merge(ref_mem[ifc.req_addr], ifc.req_wdata, ifc.req_mask);
            end else begin
                exp_q.push_back(ref_mem[ifc.req_addr]);
                exp_t.push_back(cycle + 2);
            end
        end
        if (ifc.resp_valid && ifc.resp_ready) got_q.push_back(ifc.resp_rdata);
        if (exp_vld && ifc.resp_ready) begin
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
        end
        last_acc = acc;
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic drain();
        ifc.req_valid  = 1'b0;
        ifc.resp_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Release reset and follow the zero-fill sweep; a read is offered throughout and must be refused.
    task automatic release_and_init();
        reset_n = 1'b1;
        set_req(1'b1, 1'b0, 8'h7F, '0, '0);
        for (int i = 0; i < NENT; i++) begin
            @(negedge clock);
            chk("init_cmd", {ifc.mem_en, ifc.mem_wmode, ifc.mem_addr, ifc.mem_wmask},
                {1'b1, 1'b1, 8'(i), 8'hFF});
            chk("init_wdata", ifc.mem_wdata, 0);
            chk("init_ready_done", {ifc.req_ready, ifc.init_done}, 2'b00);
            @(posedge clock);
            #1;
            cycle++;
        end
        ifc.req_valid = 1'b0;
        @(negedge clock);
        chk("init_done", ifc.init_done, 1);
        chk("idle_mem_en", ifc.mem_en, 0);
        @(posedge clock);
        #1;
        cycle++;
        for (int i = 0; i < NENT; i++) ref_mem[i] = '0;
        exp_q.delete();
        exp_t.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nrd;
        n_chk = 0;
        n_pass = 0;
        cycle = 0;
        last_acc = 1'b0;
        for (int i = 0; i < NENT; i++) macro_mem[i] = DATA_W'({$urandom(), $urandom()});
        set_req(1'b0, 1'b0, '0, '0, '0);
        ifc.resp_ready = 1'b1;

        vecs[0]  = '{1'b0, 8'h7F, 8'h00, 48'h0,            48'h0};
        vecs[1]  = '{1'b1, 8'h10, 8'hFF, 48'hABCDEF012345, 48'h0};
        vecs[2]  = '{1'b0, 8'h10, 8'h00, 48'h0,            48'hABCDEF012345};
        vecs[3]  = '{1'b1, 8'h20, 8'hFF, 48'hFFFFFFFFFFFF, 48'h0};
        vecs[4]  = '{1'b1, 8'h20, 8'h0F, 48'h000000000000, 48'h0};
        vecs[5]  = '{1'b0, 8'h20, 8'h00, 48'h0,            48'hFFFFFF000000};
        vecs[6]  = '{1'b1, 8'h30, 8'h00, 48'h123456789ABC, 48'h0};
        vecs[7]  = '{1'b0, 8'h30, 8'h00, 48'h0,            48'h0};
        vecs[8]  = '{1'b1, 8'h30, 8'hA5, 48'hFFFFFFFFFFFF, 48'h0};
        vecs[9]  = '{1'b0, 8'h30, 8'h00, 48'h0,            48'hFC0FC003F03F};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 48'h0,            48'h0};

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_outputs", {ifc.req_ready, ifc.resp_valid, ifc.init_done, ifc.mem_en}, 4'b0000);
        release_and_init();

        // Directed vector table, one request per cycle
        got_q.delete();
        nrd = 0;
        for (int i = 0; i < 11; i++) begin
            set_req(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].wdata);
            k = 0;
            do begin tick(); k++; end while (!last_acc && k < 20);
            if (!last_acc) chk("vec_accept_timeout", 0, 1);
            if (!vecs[i].wr) nrd++;
        end
        drain();
        chk("vec_resp_count", got_q.size(), nrd);
        k = 0;
        for (int i = 0; i < 11; i++) begin
            if (!vecs[i].wr) begin
                if (k < got_q.size()) chk($sformatf("vec%0d_rdata", i), got_q[k], vecs[i].exp);
                k++;
            end
        end

        // Backpressure: four reads offered with resp_ready low, then a write
        got_q.delete();
        ifc.resp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            set_req(1'b1, 1'b0, (k == 0) ? 8'h10 : (k == 1) ? 8'h20 : 8'h30, '0, '0);
            tick();
            if (last_acc) k++;
        end
        chk("bp_reads_accepted", k, 2);
        set_req(1'b1, 1'b1, 8'h40, 8'hFF, 48'h5A5A5A5A5A5A);
        tick();
        chk("bp_write_accepted", last_acc, 1);
        drain();
        chk("bp_resp_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("bp_resp0", got_q[0], 48'hABCDEF012345);
            chk("bp_resp1", got_q[1], 48'hFFFFFF000000);
        end

        // Back-to-back reads with resp_ready high
        got_q.delete();
        k = 0;
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 1'b0, 8'((i % 4) * 16 + 16), '0, '0);
            tick();
            if (last_acc) k++;
        end
        chk("b2b_accepts", k, 8);
        drain();
        chk("b2b_resp_count", got_q.size(), 8);

        // Randomized traffic over a small address window
        last_acc = 1'b0;
        ifc.req_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!ifc.req_valid || last_acc)
                set_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 7)), 8'($urandom()), DATA_W'({$urandom(), $urandom()}));
            ifc.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset while two responses are queued
        ifc.resp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && k < 2; c++) begin
            set_req(1'b1, 1'b0, 8'(k + 2), '0, '0);
            tick();
            if (last_acc) k++;
        end
        chk("rst_pre_reads", k, 2);
        ifc.req_valid = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", {ifc.req_ready, ifc.resp_valid, ifc.init_done, ifc.mem_en}, 4'b0000);
        @(posedge clock);
        @(posedge clock);
        #1;
        release_and_init();
        set_req(1'b1, 1'b0, 8'h02, '0, '0);
        ifc.resp_ready = 1'b1;
        tick();
        ifc.req_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/array_35_ctrl.md
# array_35_ctrl

Front-end controller for the 256x48 single-port, 8-lane byte-masked array macro (`array_35_ext`). It zero-initialises every entry after reset, then arbitrates a valid/ready request channel onto the macro's single RW port. Read data returns through a small response FIFO, so the 1-cycle macro read latency and consumer backpressure are hidden from the client. It sits directly upstream of the macro and drives all of its `RW0_*` inputs except the clock.

## Interface
Parameters:
- `ADDR_W`, 8: array address width (depth = 2^ADDR_W).
- `DATA_W`, 48: data width.
- `MASK_W`, 8: mask lanes; lane width is DATA_W/MASK_W = 6 bits.
- `RESP_DEPTH`, 2: response FIFO entries; must be ≥2.

Ports:
- `clock`  in  1  single clock for all logic; also drives the macro `RW0_clk`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_write`  in  1  1 = masked write, 0 = read.
- `req_addr`  in  ADDR_W  entry address.
- `req_mask`  in  MASK_W  write lane enables; ignored for reads.
- `req_wdata`  in  DATA_W  write data.
- `resp_valid`  out  1  read data available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  DATA_W  read data, in request order.
- `init_done`  out  1  high once initialisation completes; stays high until reset.
- `mem_en`, `mem_wmode`  out  1 each  to macro `RW0_en` and `RW0_wmode`.
- `mem_addr`  out  ADDR_W  to `RW0_addr`.
- `mem_wmask`  out  MASK_W  to `RW0_wmask`.
- `mem_wdata`  out  DATA_W  to `RW0_wdata`.
- `mem_rdata`  in  DATA_W  from `RW0_rdata`; valid only in the cycle after a read is issued.

## Operation
- State machine with two states.
  - INIT: entered on reset. A counter `init_addr` runs 0..2^ADDR_W−1. Each cycle issues one write: `mem_en`=1, `mem_wmode`=1, `mem_wmask`=all ones, `mem_wdata`=0. `req_ready`=0 throughout.
  - RUN: entered after the write to the last address. `init_done` is set. RUN has no exit except reset.
- In RUN, macro signals are combinational from the request:
  - `mem_en` = `req_valid && req_ready`.
  - `mem_wmode` = `req_write`.
  - `mem_addr`, `mem_wmask` and `mem_wdata` pass through from the request.
  - When idle, `mem_en`=0 and the remaining `mem_*` outputs are don't-care.
- `req_ready` in RUN:
  - Writes: always 1.
  - Reads: 1 only if `fifo_count + inflight − (resp_valid && resp_ready) < RESP_DEPTH`.
  - `req_ready` may depend on `req_valid`/`req_write`; the client must hold its payload until accepted.
- `inflight` register: set to 1 in the cycle after an accepted read, else 0. While it is 1, `mem_rdata` is pushed into the FIFO.
- A write with a zero mask is still issued to the macro and leaves the contents unchanged.
- A read issued the cycle after a write to the same address returns the new data; no forwarding is needed.
- FIFO push and pop in the same cycle are both honoured; the count is unchanged.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `init_done`=0, `mem_en`=0, FIFO empty, `inflight`=0, `init_addr`=0.
- Reset deassert at cycle 0 → INIT writes during cycles 0..255; `init_done`=1 and `req_ready` is enabled from cycle 256.
- Read accepted in cycle N → `mem_rdata` valid in N+1 → pushed at the end of N+1 → `resp_valid` in N+2. Latency is 2 cycles with `resp_ready` held high.
- With `resp_ready`=1 throughout, back-to-back reads sustain 1 per cycle.
- With `resp_ready`=0, at most RESP_DEPTH reads are outstanding: queued entries plus in-flight.
- Reset asserted mid-operation: the FIFO and in-flight read are discarded, all outputs return to reset values immediately (asynchronously), and INIT restarts from address 0.

## Structure
- Shared package `array_pkg`: ADDR_W/DATA_W/MASK_W defaults, lane width constant, state enum `{INIT, RUN}`.
- One sub-module, `array_resp_fifo`: a synchronous FIFO of depth RESP_DEPTH with registered count and async active-low reset, exposing `push`, `pop`, `count`, `head`.

## Test plan
- Reset release → exactly 256 writes with mask 0xFF and data 0 to addresses 0..255 in order; `init_done` rises at cycle 256; a read of addr 0x7F returns 0.
- Write addr 0x10, data 0xABCDEF012345, mask 0xFF, then a read in the next cycle → `resp_rdata`=0xABCDEF012345 two cycles after the read is accepted.
- Write 0xFFFFFFFFFFFF then write 0 with mask 0x0F to addr 0x20 → read returns 0xFFFFFF000000.
- `resp_ready`=0 with 4 reads offered → 2 accepted, `req_ready` drops for reads while writes are still accepted; after `resp_ready` rises, responses come out in order.
- `resp_ready`=1 with 8 back-to-back reads → one acceptance per cycle, 8 in-order responses, no stall.
- `reset_n` pulsed low while 2 responses are queued → `resp_valid`=0 immediately and INIT restarts at address 0.
